btn_conditioner: RTL and testbench

- Front-end input stage for the board-level lab controller.
- Synchronizes and debounces the four push buttons (btnD, btnR, btnU, btnL) and the 8 slide switches.
- Emits clean levels, single-cycle press/release pulses and optional hold-to-repeat press pulses.
- Sits directly upstream of the LED/state-machine block, which consumes only conditioned signals.

---
 rtl/btn_conditioner.sv | 252 +++++++++++++++++++++++++
 tb/tb_btn_conditioner.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Input conditioning front end for the lab controller: synchronizes and
// debounces four push buttons and eight slide switches, and produces clean
// levels, one-cycle press/release pulses and optional hold-to-repeat presses.

// One debounced input: 2-flop synchronizer followed by a stability counter.
// 'flip' is combinational and announces that 'level' changes on the next edge,
// so downstream registered pulses line up with the level change.
module btn_cond_db #(
  parameter int CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic flip
);
  localparam int            CW   = $clog2(CYC) + 1;
  localparam logic [CW-1:0] LAST = CW'(CYC - 1);

  logic [1:0]    sync_q, sync_d;
  logic          s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          y;

  assign y     = sync_q[1];
  assign level = s_q;

  // Count consecutive disagreeing cycles; flip the stable value on the last one.
  always_comb begin
    sync_d = {sync_q[0], raw};
    s_d    = s_q;
    cnt_d  = '0;
    flip   = 1'b0;
    if (y != s_q) begin
      if (cnt_q >= LAST) begin
        flip = 1'b1;
        s_d  = ~s_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, stable value and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      s_q    <= s_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// Per-button press/release pulse generator with hold-to-repeat FSM.
// Driven by the debouncer's 'flip' so the pulses coincide with the level edge.
module btn_cond_rpt #(
  parameter int REPEAT_EN     = 1,
  parameter int HOLD_CYCLES   = 20,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic flip,
  input  logic level,
  output logic press,
  output logic press_nxt,
  output logic rel
);
  localparam int            RMAX     = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int            RW       = $clog2(RMAX) + 1;
  localparam logic [RW-1:0] HOLD_N   = RW'(HOLD_CYCLES);
  localparam logic [RW-1:0] REPEAT_N = RW'(REPEAT_CYCLES);
  localparam logic [RW-1:0] ONE      = RW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RPT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          rise, fall;

  assign rise      = flip & ~level;
  assign fall      = flip & level;
  assign press     = press_q;
  assign press_nxt = press_d;
  assign rel       = rel_q;

  // State, repeat counter and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rcnt_q  <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // Next state: a debounced fall overrides everything; repeats only when enabled.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    if (fall) begin
      state_d = ST_IDLE;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise && (REPEAT_EN != 0)) begin
            state_d = ST_HOLD;
            rcnt_d  = ONE;
          end
        end
        ST_HOLD: begin
          if (rcnt_q == HOLD_N) begin
            state_d = ST_RPT;
            rcnt_d  = ONE;
          end else if (rcnt_q != '1) begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        ST_RPT: begin
          if (rcnt_q == REPEAT_N) begin
            rcnt_d = ONE;
          end else if (rcnt_q != '1) begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  // Pulse outputs: press on rise or repeat expiry, never in a release cycle.
  always_comb begin
    press_d = 1'b0;
    rel_d   = fall;
    if (!fall) begin
      case (state_q)
        ST_IDLE: press_d = rise;
        ST_HOLD: press_d = (rcnt_q == HOLD_N);
        ST_RPT:  press_d = (rcnt_q == REPEAT_N);
        default: press_d = 1'b0;
      endcase
    end
  end
endmodule

// Top: four button channels (debounce + repeat) and eight switch channels.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_EN       = 1,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnD,
  input  logic       btnR,
  input  logic       btnU,
  input  logic       btnL,
  input  logic [7:0] sw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic       any_press,
  output logic [7:0] sw_level,
  output logic       sw_changed
);
  localparam int NUM_BTN = 4;
  localparam int NUM_SW  = 8;

  logic [NUM_BTN-1:0] btn_raw, btn_flip, btn_press_nxt;
  logic [NUM_SW-1:0]  sw_flip;
  logic               any_press_q, any_press_d;
  logic               sw_changed_q, sw_changed_d;

  assign btn_raw    = {btnL, btnU, btnR, btnD};
  assign any_press  = any_press_q;
  assign sw_changed = sw_changed_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_cond_db #(
      .CYC (DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[i]),
      .level (btn_level[i]),
      .flip  (btn_flip[i])
    );

    btn_cond_rpt #(
      .REPEAT_EN     (REPEAT_EN),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_rpt (
      .clk       (clk),
      .rst       (rst),
      .flip      (btn_flip[i]),
      .level     (btn_level[i]),
      .press     (btn_press[i]),
      .press_nxt (btn_press_nxt[i]),
      .rel       (btn_release[i])
    );
  end

  for (genvar j = 0; j < NUM_SW; j++) begin : g_sw
    btn_cond_db #(
      .CYC (DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (sw[j]),
      .level (sw_level[j]),
      .flip  (sw_flip[j])
    );
  end

  // Summary pulses are computed from next-cycle values so they align with their sources.
  always_comb begin
    any_press_d  = |btn_press_nxt;
    sw_changed_d = |sw_flip;
  end

  // Summary pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_press_q  <= 1'b0;
      sw_changed_q <= 1'b0;
    end else begin
      any_press_q  <= any_press_d;
      sw_changed_q <= sw_changed_d;
    end
  end
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: one repeat-enabled and one repeat-disabled
// instance share the same stimulus; expected values are hand-computed cycle counts.
module tb_btn_conditioner;
  localparam int DB = 4;
  localparam int HC = 20;
  localparam int RC = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btnD = 1'b0, btnR = 1'b0, btnU = 1'b0, btnL = 1'b0;
  logic [7:0] sw = 8'h00;

  logic [3:0] r_lvl, r_prs, r_rel;
  logic       r_any, r_chg;
  logic [7:0] r_sw;
  logic [3:0] n_lvl, n_prs, n_rel;
  logic       n_any, n_chg;
  logic [7:0] n_sw;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DB), .REPEAT_EN (1), .HOLD_CYCLES (HC), .REPEAT_CYCLES (RC)
  ) u_rep (
    .clk (clk), .rst (rst), .btnD (btnD), .btnR (btnR), .btnU (btnU), .btnL (btnL),
    .sw (sw), .btn_level (r_lvl), .btn_press (r_prs), .btn_release (r_rel),
    .any_press (r_any), .sw_level (r_sw), .sw_changed (r_chg)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DB), .REPEAT_EN (0), .HOLD_CYCLES (HC), .REPEAT_CYCLES (RC)
  ) u_norep (
    .clk (clk), .rst (rst), .btnD (btnD), .btnR (btnR), .btnU (btnU), .btnL (btnL),
    .sw (sw), .btn_level (n_lvl), .btn_press (n_prs), .btn_release (n_rel),
    .any_press (n_any), .sw_level (n_sw), .sw_changed (n_chg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Checks the repeat-enabled instance's button outputs, any_press included.
  task automatic chk_btn(input string tag, input logic [3:0] l, input logic [3:0] p, input logic [3:0] r);
    chk({tag, ".level"},   32'(r_lvl), 32'(l));
    chk({tag, ".press"},   32'(r_prs), 32'(p));
    chk({tag, ".release"}, 32'(r_rel), 32'(r));
    chk({tag, ".any"},     32'(r_any), 32'(|p));
  endtask

  task automatic chk_all_zero(input string tag);
    chk_btn(tag, 4'h0, 4'h0, 4'h0);
    chk({tag, ".sw_level"},   32'(r_sw),  32'h0);
    chk({tag, ".sw_changed"}, 32'(r_chg), 32'h0);
    chk({tag, ".nr_level"},   32'(n_lvl), 32'h0);
    chk({tag, ".nr_press"},   32'(n_prs), 32'h0);
    chk({tag, ".nr_release"}, 32'(n_rel), 32'h0);
    chk({tag, ".nr_any"},     32'(n_any), 32'h0);
    chk({tag, ".nr_sw"},      32'(n_sw),  32'h0);
    chk({tag, ".nr_chg"},     32'(n_chg), 32'h0);
  endtask

  initial begin
    int c_rep, c_nr;
    logic [3:0] ep;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick(); tick();
    chk_all_zero("idle");

    // Clean press on btnD: rise on 6th edge, repeats at +20/+28/+36, fall 6 edges after release
    btnD = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_btn("clean_wait", 4'h0, 4'h0, 4'h0);
    end
    tick();
    chk_btn("clean_rise", 4'h1, 4'h1, 4'h0);
    chk("clean_rise.nr_press", 32'(n_prs), 32'h1);
    for (int k = 1; k <= 44; k++) begin
      tick();
      ep = ((k == 20) || (k == 28) || (k == 36)) ? 4'h1 : 4'h0;
      chk_btn("clean_hold", (k < 40) ? 4'h1 : 4'h0, ep, (k == 40) ? 4'h1 : 4'h0);
      chk("clean_hold.nr_press", 32'(n_prs), 32'h0);
      chk("clean_hold.nr_release", 32'(n_rel), (k == 40) ? 32'h1 : 32'h0);
      if (k == 34) btnD = 1'b0;
    end

    // Glitch reject on btnR: 3 high, 10 low, 3 high
    btnR = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); chk_btn("glitch", 4'h0, 4'h0, 4'h0); end
    btnR = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); chk_btn("glitch", 4'h0, 4'h0, 4'h0); end
    btnR = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); chk_btn("glitch", 4'h0, 4'h0, 4'h0); end
    btnR = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); chk_btn("glitch", 4'h0, 4'h0, 4'h0); end

    // Bounce on btnU: toggle every 2 cycles for 20 cycles, then steady high
    for (int i = 0; i < 10; i++) begin
      btnU = (i % 2 == 0);
      tick(); chk_btn("bounce", 4'h0, 4'h0, 4'h0);
      tick(); chk_btn("bounce", 4'h0, 4'h0, 4'h0);
    end
    btnU = 1'b1;
    for (int i = 1; i <= 5; i++) begin tick(); chk_btn("bounce_settle", 4'h0, 4'h0, 4'h0); end
    tick(); chk_btn("bounce_rise", 4'h4, 4'h4, 4'h0);
    tick(); chk_btn("bounce_after", 4'h4, 4'h0, 4'h0);
    btnU = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); chk_btn("bounce_hold", 4'h4, 4'h0, 4'h0); end
    tick(); chk_btn("bounce_fall", 4'h0, 4'h0, 4'h4);

    // Simultaneous btnL + btnD
    btnL = 1'b1; btnD = 1'b1;
    for (int i = 0; i < 5; i++) begin tick(); chk_btn("simul_wait", 4'h0, 4'h0, 4'h0); end
    tick();
    chk_btn("simul_rise", 4'h9, 4'h9, 4'h0);
    chk("simul_rise.nr_any", 32'(n_any), 32'h1);
    tick(); chk_btn("simul_after", 4'h9, 4'h0, 4'h0);
    btnL = 1'b0; btnD = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); chk_btn("simul_hold", 4'h9, 4'h0, 4'h0); end
    tick(); chk_btn("simul_fall", 4'h0, 4'h0, 4'h9);

    // Reset mid-hold on btnR; still held afterwards counts as a fresh press
    btnR = 1'b1;
    for (int i = 0; i < 5; i++) begin tick(); chk_btn("rsth_wait", 4'h0, 4'h0, 4'h0); end
    tick(); chk_btn("rsth_rise", 4'h2, 4'h2, 4'h0);
    for (int i = 0; i < 5; i++) begin tick(); chk_btn("rsth_hold", 4'h2, 4'h0, 4'h0); end
    rst = 1'b1;
    tick();
    chk_all_zero("rsth_reset");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); chk_btn("rsth_resync", 4'h0, 4'h0, 4'h0); end
    tick(); chk_btn("rsth_rerise", 4'h2, 4'h2, 4'h0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk_btn("rsth_repeat", 4'h2, (k == 20) ? 4'h2 : 4'h0, 4'h0);
    end
    btnR = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); chk_btn("rsth_rel", 4'h2, 4'h0, 4'h0); end
    tick(); chk_btn("rsth_fall", 4'h0, 4'h0, 4'h2);

    // Switches 0x00 -> 0xA5 -> 0x0F
    sw = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sw_wait.level", 32'(r_sw), 32'h00);
      chk("sw_wait.changed", 32'(r_chg), 32'h0);
    end
    tick();
    chk("sw_a5.level", 32'(r_sw), 32'hA5);
    chk("sw_a5.changed", 32'(r_chg), 32'h1);
    chk("sw_a5.nr_level", 32'(n_sw), 32'hA5);
    tick();
    chk("sw_a5_after.level", 32'(r_sw), 32'hA5);
    chk("sw_a5_after.changed", 32'(r_chg), 32'h0);
    sw = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sw_0f_wait.level", 32'(r_sw), 32'hA5);
      chk("sw_0f_wait.changed", 32'(r_chg), 32'h0);
    end
    tick();
    chk("sw_0f.level", 32'(r_sw), 32'h0F);
    chk("sw_0f.changed", 32'(r_chg), 32'h1);
    tick();
    chk("sw_0f_after.changed", 32'(r_chg), 32'h0);

    // btnD held 60 cycles: one press without repeat, 6 presses with repeat
    c_rep = 0;
    c_nr  = 0;
    btnD = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      c_rep += int'(r_prs[0]);
      c_nr  += int'(n_prs[0]);
    end
    chk("norep.count", 32'(c_nr), 32'd1);
    chk("rep.count", 32'(c_rep), 32'd6);
    btnD = 1'b0;
    for (int i = 1; i <= 5; i++) begin tick(); chk("norep_hold.level", 32'(n_lvl), 32'h1); end
    // Repeat expiry coincides with the fall here; the release must win
    tick();
    chk_btn("rep_fall", 4'h0, 4'h0, 4'h1);
    chk("norep_fall.level", 32'(n_lvl), 32'h0);
    chk("norep_fall.release", 32'(n_rel), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
